forward_scoreboard: RTL and testbench
=====================================

# forward_scoreboard

Parametrised operand-forwarding and hazard unit for the decode/issue stage. It resolves NUM_READ source operands against NUM_STAGES in-order pipeline stages and a completion port for long-latency units (divider, non-blocking loads). A 31-entry pending-register scoreboard tracks outstanding long-latency writes across cycles. The block stalls issue on read-after-write (RAW) and write-after-write (WAW) hazards and counts stall cycles for performance monitoring.

## Interface
Parameters:
- NUM_READ, 2: source operand ports, 1..4.
- NUM_STAGES, 3: forwarding stages; index 0 is the youngest (EX), NUM_STAGES-1 the oldest (WB); 1..6.
- CNT_W, 32: stall counter width.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; asynchronous assert, active-low.
- i_rs  in  NUM_READ x rv32_register  source register per read port.
- i_rs_used  in  NUM_READ  port p actually reads i_rs[p].
- i_rf_data  in  NUM_READ x 32  register-file read data.
- i_stage_valid  in  NUM_STAGES  stage s holds a register-writing instruction.
- i_stage_rd  in  NUM_STAGES x rv32_register  destination register of stage s.
- i_stage_ready  in  NUM_STAGES  result of stage s is available this cycle (0 = load not yet returned).
- i_stage_data  in  NUM_STAGES x 32  result of stage s.
- i_issue_valid  in  1  instruction in decode requests issue.
- i_issue_rd  in  rv32_register  its destination register.
- i_issue_long  in  1  its result returns via the completion port.
- i_cpl_valid  in  1  long-latency result delivered.
- i_cpl_rd  in  rv32_register  destination of the completion.
- i_cpl_data  in  32  completion data.
- i_flush  in  1  pipeline flush.
- o_data  out  NUM_READ x 32  forwarded operands.
- o_hazard  out  1  stall decode this cycle.
- o_pending  out  32  scoreboard mask; bit 0 is always 0.
- o_stall_cycles  out  CNT_W  saturating hazard-cycle count.

## Operation
- **Operand source per port p.** The first match in priority order wins:
  - stage 0 .. NUM_STAGES-1 where i_stage_valid[s] && i_stage_rd[s]==i_rs[p];
  - then the completion port, when i_cpl_valid && i_cpl_rd==i_rs[p];
  - otherwise i_rf_data[p].
- **x0 and unused ports.** If i_rs[p]==0 or !i_rs_used[p], the port never matches: o_data[p]=i_rf_data[p] and the port contributes no hazard.
- **Raw hazard on port p.** Asserted when either:
  - the winning stage match has i_stage_ready=0; or
  - no stage matches, pending[i_rs[p]]=1, and the completion port does not deliver that register this cycle.
- **WAW hazard.** Asserted when i_issue_valid && i_issue_rd!=0 && pending[i_issue_rd]=1 && !(i_cpl_valid && i_cpl_rd==i_issue_rd).
- **o_hazard** is the OR of all raw hazards and the WAW hazard, combinational.
- **Effective issue** = i_issue_valid && !o_hazard && !i_flush.
- **Pending update at each clock edge, in priority order:**
  - i_flush: the mask clears to 0. Completions in the flush cycle are discarded.
  - Otherwise, the completion clears bit i_cpl_rd.
  - An effective issue with i_issue_long and i_issue_rd!=0 sets bit i_issue_rd. When set and clear target the same register, set wins.
- **Stall counter.** Increments when o_hazard=1, saturates at all-ones, and is never cleared except by reset.
- **Long-latency contract.** Long-latency units drop in-flight results on i_flush. Long instructions present i_stage_valid=0 in the forwarding stages.

## Timing
- **Reset:** pending=0, o_stall_cycles=0. All other outputs are combinational from inputs and pending.
- **Combinational paths:** operand-to-o_data and o_hazard are zero latency.
- **Issue latency:** a long issue in cycle t is visible in o_pending from cycle t+1. A consumer in cycle t+1 stalls unless the completion arrives in that same cycle.
- **Completion visibility:** a completion in cycle t is forwarded in cycle t and is absent from o_pending from t+1. The register file must hold the value from t+1.
- **Reset during operation:** reset asserted mid-operation clears the scoreboard immediately (asynchronous). Outstanding completions after reset are the long-latency unit's responsibility.

## Structure
- Package `types` holds rv32_register and a new constant RV32_NUM_REGS=32.
- Reuse the `lzd` sub-module, one instance per read port, to priority-encode the NUM_STAGES+2 match vector. The input is {1'b1, cpl_match, stage_match[NUM_STAGES-1:0]}. The index selects both data and the hazard bit.
- The scoreboard and counter are local always_ff blocks. No new sub-module.

## Test plan
- **Stage priority.** Stages 0 and 2 both write x5 with data 0xAAAA/0xCCCC, all ready; i_rs[0]=5 → o_data[0]=0xAAAA, o_hazard=0.
- **Load-use.** Stage 0 writes x7 with ready=0; i_rs[1]=7 → o_hazard=1. Next cycle stage 1 ready with 0x1234 → o_data[1]=0x1234, o_hazard=0, and o_stall_cycles has incremented by 1.
- **Long op lifecycle.** Issue long to x9 → o_pending=0x200 at t+1. Read x9 → hazard. Completion x9 with 0xDEAD in the same cycle as the read → o_data=0xDEAD, no hazard. Next cycle o_pending=0.
- **WAW and set-wins.** With x3 pending, issuing to x3 → hazard. With a completion x3 and a long issue to x3 in the same cycle → no hazard, and o_pending[3]=1 afterwards.
- **x0 and flush.** i_rs=0 while a stage writes x0 → o_data=i_rf_data, no hazard. With pending=0x0F0, i_flush plus a completion x4 → pending=0 next cycle.
- **Saturation and reset.** Run with CNT_W=4 and 20 hazard cycles → o_stall_cycles=15. Then assert i_rst_n=0 asynchronously → counter and pending read 0 before the next edge.

Source files
------------

// File: rtl/forward_scoreboard_pkg.sv
// rtl/forward_scoreboard_pkg.sv - shared RV32 register types for the forwarding/hazard unit
//
// Purpose : register-index type and register-file size used by the
//           forwarding scoreboard and its bench.
// Ports   : none (package).
package types;

   typedef logic [4:0] rv32_register;

   localparam int RV32_NUM_REGS = 32;

endpackage

// File: rtl/lzd.sv
// rtl/lzd.sv - priority encoder returning the index of the lowest set bit
//
// Purpose : selects the highest-priority request; bit 0 has top priority.
// Ports   : i_vec  in  WIDTH  request vector
//           o_idx  out IDX_W  index of the lowest set bit (0 when none set)
module lzd #(
   parameter int WIDTH = 4,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] i_vec,
   output logic [IDX_W-1:0] o_idx
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      o_idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (i_vec[i]) o_idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/forward_scoreboard.sv
// rtl/forward_scoreboard.sv - operand forwarding, RAW/WAW hazard detection and pending scoreboard
//
// Purpose : resolves NUM_READ source operands against NUM_STAGES in-order
//           stages and a long-latency completion port, tracks outstanding
//           long-latency writes and counts stall cycles.
// Ports   : i_clk, i_rst_n                     clock, async active-low reset
//           i_rs / i_rs_used / i_rf_data       per read port source, use flag, RF data
//           i_stage_valid/rd/ready/data        per stage forwarding sources (0 = youngest)
//           i_issue_valid/rd/long              instruction requesting issue
//           i_cpl_valid/rd/data                long-latency completion
//           i_flush                            pipeline flush
//           o_data                             forwarded operands
//           o_hazard                           stall decode this cycle
//           o_pending                          outstanding long-latency writes (bit 0 = 0)
//           o_stall_cycles                     saturating hazard-cycle count
module forward_scoreboard
   import types::*;
#(
   parameter int NUM_READ   = 2,
   parameter int NUM_STAGES = 3,
   parameter int CNT_W      = 32
) (
   input  logic                                i_clk,
   input  logic                                i_rst_n,
   input  rv32_register [NUM_READ-1:0]         i_rs,
   input  logic [NUM_READ-1:0]                 i_rs_used,
   input  logic [NUM_READ-1:0][31:0]           i_rf_data,
   input  logic [NUM_STAGES-1:0]               i_stage_valid,
   input  rv32_register [NUM_STAGES-1:0]       i_stage_rd,
   input  logic [NUM_STAGES-1:0]               i_stage_ready,
   input  logic [NUM_STAGES-1:0][31:0]         i_stage_data,
   input  logic                                i_issue_valid,
   input  rv32_register                        i_issue_rd,
   input  logic                                i_issue_long,
   input  logic                                i_cpl_valid,
   input  rv32_register                        i_cpl_rd,
   input  logic [31:0]                         i_cpl_data,
   input  logic                                i_flush,
   output logic [NUM_READ-1:0][31:0]           o_data,
   output logic                                o_hazard,
   output logic [RV32_NUM_REGS-1:0]            o_pending,
   output logic [CNT_W-1:0]                    o_stall_cycles
);

   // Match vector: stages, then completion, then the always-true RF fallback.
   localparam int VEC_W = NUM_STAGES + 2;
   localparam int IDX_W = $clog2(VEC_W);

   logic [RV32_NUM_REGS-1:0] r_pending;
   logic [RV32_NUM_REGS-1:0] w_pending_nxt;
   logic [CNT_W-1:0]         r_stall;
   logic [NUM_READ-1:0]      w_raw;
   logic                     w_waw;
   logic                     w_hazard;
   logic                     w_issue_eff;

   for (genvar p = 0; p < NUM_READ; p++) begin : g_port
      logic             w_active;
      logic [VEC_W-1:0] w_match;
      logic [IDX_W-1:0] w_idx;
      logic [31:0]      w_sel_data;
      logic             w_sel_haz;

      // x0 and unused ports never match anything, so they fall through to RF.
      assign w_active = i_rs_used[p] && (i_rs[p] != '0);

      always_comb begin
         w_match = '0;
         for (int s = 0; s < NUM_STAGES; s++) begin
            w_match[s] = w_active && i_stage_valid[s] && (i_stage_rd[s] == i_rs[p]);
         end
         w_match[NUM_STAGES]     = w_active && i_cpl_valid && (i_cpl_rd == i_rs[p]);
         w_match[NUM_STAGES + 1] = 1'b1;
      end

      lzd #(.WIDTH(VEC_W)) u_lzd (
         .i_vec (w_match),
         .o_idx (w_idx)
      );

      // The RF fallback is only hazardous while the register is still owed by
      // a long-latency unit; a same-cycle completion would have matched above.
      always_comb begin
         w_sel_data = i_rf_data[p];
         w_sel_haz  = w_active && r_pending[i_rs[p]];
         for (int s = 0; s < NUM_STAGES; s++) begin
            if (w_idx == IDX_W'(s)) begin
               w_sel_data = i_stage_data[s];
               w_sel_haz  = !i_stage_ready[s];
            end
         end
         if (w_idx == IDX_W'(NUM_STAGES)) begin
            w_sel_data = i_cpl_data;
            w_sel_haz  = 1'b0;
         end
      end

      assign o_data[p] = w_sel_data;
      assign w_raw[p]  = w_sel_haz;
   end

   assign w_waw = i_issue_valid && (i_issue_rd != '0) && r_pending[i_issue_rd]
                  && !(i_cpl_valid && (i_cpl_rd == i_issue_rd));

   assign w_hazard    = (|w_raw) || w_waw;
   assign w_issue_eff = i_issue_valid && !w_hazard && !i_flush;

   // Set is applied after clear so a same-register issue overrides a completion.
   always_comb begin
      w_pending_nxt = r_pending;
      if (i_flush) begin
         w_pending_nxt = '0;
      end else begin
         if (i_cpl_valid) w_pending_nxt[i_cpl_rd] = 1'b0;
         if (w_issue_eff && i_issue_long && (i_issue_rd != '0)) begin
            w_pending_nxt[i_issue_rd] = 1'b1;
         end
      end
      w_pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_pending <= '0;
      else          r_pending <= w_pending_nxt;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                        r_stall <= '0;
      else if (w_hazard && (r_stall != '1)) r_stall <= r_stall + CNT_W'(1);
   end

   assign o_hazard       = w_hazard;
   assign o_pending      = r_pending;
   assign o_stall_cycles = r_stall;

endmodule

// File: tb/tb_forward_scoreboard.sv
// tb/tb_forward_scoreboard.sv - directed scoreboard bench for forward_scoreboard
module tb_forward_scoreboard;
   import types::*;

   localparam int K_D0 = 0, K_D1 = 1, K_HAZ = 2, K_PEND = 3, K_STALL = 4;

   typedef struct {
      int          kind;
      logic [31:0] val;
      string       tag;
   } exp_t;

   logic                   clk = 1'b0;
   logic                   rst_n;
   rv32_register [1:0]     rs;
   logic [1:0]             rs_used;
   logic [1:0][31:0]       rf_data;
   logic [2:0]             st_valid;
   rv32_register [2:0]     st_rd;
   logic [2:0]             st_ready;
   logic [2:0][31:0]       st_data;
   logic                   iss_valid;
   rv32_register           iss_rd;
   logic                   iss_long;
   logic                   cpl_valid;
   rv32_register           cpl_rd;
   logic [31:0]            cpl_data;
   logic                   flush;
   logic [1:0][31:0]       o_data;
   logic                   o_hazard;
   logic [31:0]            o_pending;
   logic [3:0]             o_stall;

   exp_t       q[$];
   int         n_assert = 0;
   int         n_fail   = 0;
   logic [3:0] exp_cnt  = 4'd0;

   forward_scoreboard #(.NUM_READ(2), .NUM_STAGES(3), .CNT_W(4)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_rs           (rs),
      .i_rs_used      (rs_used),
      .i_rf_data      (rf_data),
      .i_stage_valid  (st_valid),
      .i_stage_rd     (st_rd),
      .i_stage_ready  (st_ready),
      .i_stage_data   (st_data),
      .i_issue_valid  (iss_valid),
      .i_issue_rd     (iss_rd),
      .i_issue_long   (iss_long),
      .i_cpl_valid    (cpl_valid),
      .i_cpl_rd       (cpl_rd),
      .i_cpl_data     (cpl_data),
      .i_flush        (flush),
      .o_data         (o_data),
      .o_hazard       (o_hazard),
      .o_pending      (o_pending),
      .o_stall_cycles (o_stall)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] observe(input int kind);
      case (kind)
         K_D0:    return o_data[0];
         K_D1:    return o_data[1];
         K_HAZ:   return {31'b0, o_hazard};
         K_PEND:  return o_pending;
         default: return {28'b0, o_stall};
      endcase
   endfunction

   task automatic push(input int kind, input logic [31:0] val, input string tag);
      exp_t e;
      e.kind = kind;
      e.val  = val;
      e.tag  = tag;
      q.push_back(e);
   endtask

   task automatic check_all();
      exp_t        e;
      logic [31:0] obs;
      while (q.size() > 0) begin
         e   = q.pop_front();
         obs = observe(e.kind);
         n_assert++;
         assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic idle();
      rs        = '0;
      rs_used   = '0;
      rf_data[0] = 32'hF0F0_0000;
      rf_data[1] = 32'h1111_0001;
      st_valid  = '0;
      st_rd     = '0;
      st_ready  = '1;
      st_data   = '0;
      iss_valid = 1'b0;
      iss_rd    = '0;
      iss_long  = 1'b0;
      cpl_valid = 1'b0;
      cpl_rd    = '0;
      cpl_data  = '0;
      flush     = 1'b0;
   endtask

   // Checks the current cycle's outputs, then advances; the counter model
   // follows the hazard expectation of each cycle.
   task automatic cycle(input bit haz, input string tag);
      push(K_HAZ, {31'b0, haz}, {tag, "_hazard"});
      push(K_STALL, {28'b0, exp_cnt}, {tag, "_stall"});
      #1;
      check_all();
      @(posedge clk);
      if (haz && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
      @(negedge clk);
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      #12;
      push(K_PEND, 32'h0, "reset_pending");
      cycle(1'b0, "reset");
      rst_n = 1'b1;

      // Stage priority: youngest stage wins; unused port passes RF through
      idle();
      st_valid = 3'b101; st_rd[0] = 5'd5; st_rd[2] = 5'd5;
      st_data[0] = 32'hAAAA; st_data[2] = 32'hCCCC;
      rs[0] = 5'd5; rs_used[0] = 1'b1; rs[1] = 5'd5;
      push(K_D0, 32'hAAAA, "prio_d0");
      push(K_D1, 32'h1111_0001, "unused_d1");
      cycle(1'b0, "prio");

      // Load-use
      idle();
      st_valid[0] = 1'b1; st_rd[0] = 5'd7; st_ready[0] = 1'b0;
      rs[1] = 5'd7; rs_used[1] = 1'b1;
      cycle(1'b1, "loaduse");
      idle();
      st_valid[1] = 1'b1; st_rd[1] = 5'd7; st_data[1] = 32'h1234;
      rs[1] = 5'd7; rs_used[1] = 1'b1;
      push(K_D1, 32'h1234, "loaduse_fwd");
      cycle(1'b0, "loaduse_ok");

      // Long op lifecycle
      idle();
      iss_valid = 1'b1; iss_rd = 5'd9; iss_long = 1'b1;
      push(K_PEND, 32'h0, "long_issue_pend");
      cycle(1'b0, "long_issue");
      idle();
      rs[0] = 5'd9; rs_used[0] = 1'b1;
      push(K_PEND, 32'h200, "long_pend");
      push(K_D0, 32'hF0F0_0000, "long_stall_d0");
      cycle(1'b1, "long_read");
      idle();
      rs[0] = 5'd9; rs_used[0] = 1'b1;
      cpl_valid = 1'b1; cpl_rd = 5'd9; cpl_data = 32'hDEAD;
      push(K_D0, 32'hDEAD, "cpl_fwd");
      push(K_PEND, 32'h200, "cpl_pend_still");
      cycle(1'b0, "cpl");
      idle();
      push(K_PEND, 32'h0, "cpl_cleared");
      cycle(1'b0, "after_cpl");

      // WAW and set-wins
      idle();
      iss_valid = 1'b1; iss_rd = 5'd3; iss_long = 1'b1;
      cycle(1'b0, "x3_issue");
      idle();
      iss_valid = 1'b1; iss_rd = 5'd3; iss_long = 1'b1;
      push(K_PEND, 32'h8, "waw_pend");
      cycle(1'b1, "waw");
      idle();
      iss_valid = 1'b1; iss_rd = 5'd3; iss_long = 1'b1;
      cpl_valid = 1'b1; cpl_rd = 5'd3;
      cycle(1'b0, "waw_cpl");
      idle();
      cpl_valid = 1'b1; cpl_rd = 5'd3;
      push(K_PEND, 32'h8, "set_wins");
      cycle(1'b0, "x3_clear");

      // x0 never forwards nor stalls
      idle();
      st_valid[0] = 1'b1; st_rd[0] = 5'd0; st_ready[0] = 1'b0; st_data[0] = 32'h5555;
      rs_used = 2'b11;
      rf_data[0] = 32'h77;
      push(K_D0, 32'h77, "x0_d0");
      push(K_D1, 32'h1111_0001, "x0_d1");
      push(K_PEND, 32'h0, "x3_cleared");
      cycle(1'b0, "x0");

      // Flush drops pending and same-cycle completions
      for (int r = 4; r < 8; r++) begin
         idle();
         iss_valid = 1'b1; iss_rd = 5'(r); iss_long = 1'b1;
         cycle(1'b0, "fill");
      end
      idle();
      flush = 1'b1; cpl_valid = 1'b1; cpl_rd = 5'd4;
      push(K_PEND, 32'h0F0, "flush_pre");
      cycle(1'b0, "flush");
      idle();
      push(K_PEND, 32'h0, "flush_post");
      cycle(1'b0, "after_flush");

      // Saturation, then asynchronous reset
      idle();
      iss_valid = 1'b1; iss_rd = 5'd9; iss_long = 1'b1;
      cycle(1'b0, "sat_issue");
      for (int i = 0; i < 20; i++) begin
         idle();
         st_valid[0] = 1'b1; st_rd[0] = 5'd7; st_ready[0] = 1'b0;
         rs[0] = 5'd7; rs_used[0] = 1'b1;
         cycle(1'b1, "sat");
      end
      idle();
      push(K_STALL, 32'hF, "saturated");
      push(K_PEND, 32'h200, "sat_pend");
      cycle(1'b0, "sat_done");
      #2;
      rst_n = 1'b0;
      #1;
      push(K_PEND, 32'h0, "async_rst_pend");
      push(K_STALL, 32'h0, "async_rst_stall");
      check_all();
      exp_cnt = 4'd0;
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b0, "post_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
